// File: rtl/stream_mux.sv
// rtl/stream_mux.sv - N-channel stream multiplexer with fixed or round-robin selection and a registered output stage
module stream_mux #(
  parameter int N  = 8,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [SW-1:0]  s,
  input  logic           mode,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [SW-1:0]  out_sel
);

  // Round-robin search start; it only advances on round-robin transfers.
  logic [SW-1:0] ptr;

  // Arbitration result for the current cycle.
  logic          grant_any;
  logic [SW-1:0] grant_idx;
  logic [N-1:0]  grant;
  logic [W-1:0]  grant_data;

  // The output register can take a word when empty or being drained.
  // Reset gates it so no input is acknowledged while the block is held.
  logic load;
  assign load = rst_n & (~out_valid | out_ready);

  // Pick a channel: either the one named by s, or the first valid one
  // found searching upward from ptr with wrap-around.
  always_comb begin
    logic [SW:0]   sum;
    logic [SW-1:0] idx;
    grant_any = 1'b0;
    grant_idx = '0;
    sum       = '0;
    idx       = '0;
    if (!mode) begin
      // s values at or above N match no channel, so they yield no grant.
      for (int i = 0; i < N; i++) begin
        if (!grant_any && (s == SW'(i)) && in_valid[i]) begin
          grant_any = 1'b1;
          grant_idx = SW'(i);
        end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        sum = {1'b0, ptr} + (SW+1)'(k);
        if (sum >= (SW+1)'(N)) begin
          sum = sum - (SW+1)'(N);
        end
        idx = sum[SW-1:0];
        if (!grant_any && in_valid[idx]) begin
          grant_any = 1'b1;
          grant_idx = idx;
        end
      end
    end
  end

  // One-hot grant vector and the data word of the granted channel.
  always_comb begin
    grant      = '0;
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_any && (grant_idx == SW'(i))) begin
        grant[i]   = 1'b1;
        grant_data = in_data[i*W +: W];
      end
    end
  end

  // Only the granted channel sees ready, and only when the register can load.
  assign in_ready = load ? grant : '0;

  // Output register: load the granted word, or drop valid when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (load) begin
      if (grant_any) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_sel   <= grant_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // Advance the round-robin pointer past the channel that just transferred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (load && grant_any && mode) begin
      ptr <= (grant_idx == SW'(N-1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_mux.sv
// tb/tb_stream_mux.sv - directed scoreboard bench for stream_mux (N=8 and N=5 instances)
module tb_stream_mux;

  typedef struct {
    logic [7:0] data;
    logic [2:0] sel;
  } exp_t;

  logic clk;
  logic rst_n;

  logic [63:0] in_data8;
  logic [7:0]  in_valid8;
  logic [7:0]  in_ready8;
  logic [2:0]  s8;
  logic        mode8;
  logic [7:0]  out_data8;
  logic        out_valid8;
  logic        out_ready8;
  logic [2:0]  out_sel8;

  logic [39:0] in_data5;
  logic [4:0]  in_valid5;
  logic [4:0]  in_ready5;
  logic [2:0]  s5;
  logic        mode5;
  logic [7:0]  out_data5;
  logic        out_valid5;
  logic        out_ready5;
  logic [2:0]  out_sel5;

  logic [7:0] cd8 [8];
  logic [7:0] cd5 [5];
  exp_t sb8[$];
  exp_t sb5[$];
  int checks;
  int failures;

  stream_mux #(.N(8), .W(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data8), .in_valid(in_valid8), .in_ready(in_ready8),
    .s(s8), .mode(mode8),
    .out_data(out_data8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out_sel(out_sel8)
  );

  stream_mux #(.N(5), .W(8)) dut5 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
    .s(s5), .mode(mode5),
    .out_data(out_data5), .out_valid(out_valid5), .out_ready(out_ready5),
    .out_sel(out_sel5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setd8(input int i, input logic [7:0] v);
    cd8[i] = v;
    in_data8[i*8 +: 8] = v;
  endtask

  task automatic setd5(input int i, input logic [7:0] v);
    cd5[i] = v;
    in_data5[i*8 +: 8] = v;
  endtask

  // Called at posedge+1: check ready mid-cycle, push the expected word if a
  // transfer should happen, then pop and compare just after the next edge.
  task automatic cycle8(input string tag, input logic [7:0] exp_rdy, input bit xfer, input int sel);
    exp_t e;
    #3;
    chk({tag, "_rdy"}, 64'(in_ready8), 64'(exp_rdy));
    if (xfer) sb8.push_back('{data: cd8[sel], sel: 3'(sel)});
    @(posedge clk); #1;
    if (xfer) begin
      e = sb8.pop_front();
      chk({tag, "_valid"}, 64'(out_valid8), 64'd1);
      chk({tag, "_data"}, 64'(out_data8), 64'(e.data));
      chk({tag, "_sel"}, 64'(out_sel8), 64'(e.sel));
    end
  endtask

  task automatic cycle5(input string tag, input logic [4:0] exp_rdy, input bit xfer, input int sel);
    exp_t e;
    #3;
    chk({tag, "_rdy"}, 64'(in_ready5), 64'(exp_rdy));
    if (xfer) sb5.push_back('{data: cd5[sel], sel: 3'(sel)});
    @(posedge clk); #1;
    if (xfer) begin
      e = sb5.pop_front();
      chk({tag, "_valid"}, 64'(out_valid5), 64'd1);
      chk({tag, "_data"}, 64'(out_data5), 64'(e.data));
      chk({tag, "_sel"}, 64'(out_sel5), 64'(e.sel));
    end
  endtask

  initial begin
    logic [2:0] s_seq [3];
    checks   = 0;
    failures = 0;
    s_seq[0] = 3'd5; s_seq[1] = 3'd1; s_seq[2] = 3'd7;

    rst_n      = 1'b0;
    in_data8   = '0;
    in_valid8  = 8'hFF;
    s8         = 3'd0;
    mode8      = 1'b0;
    out_ready8 = 1'b1;
    in_data5   = '0;
    in_valid5  = 5'h1F;
    s5         = 3'd0;
    mode5      = 1'b0;
    out_ready5 = 1'b1;
    for (int i = 0; i < 8; i++) setd8(i, 8'h40 + 8'(i));
    for (int i = 0; i < 5; i++) setd5(i, 8'h50 + 8'(i));

    // Reset state, with inputs requesting
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid8), 64'd0);
    chk("rst_data", 64'(out_data8), 64'd0);
    chk("rst_sel", 64'(out_sel8), 64'd0);
    chk("rst_rdy", 64'(in_ready8), 64'd0);
    chk("rst_valid5", 64'(out_valid5), 64'd0);
    chk("rst_rdy5", 64'(in_ready5), 64'd0);

    // Fixed select S=3; first grant on the first edge after release
    in_valid8 = 8'h08;
    in_valid5 = 5'h00;
    s8 = 3'd3;
    setd8(3, 8'hA5);
    rst_n = 1'b1;
    cycle8("fix_s3", 8'h08, 1, 3);

    // Nothing valid: valid drops, data and sel hold
    in_valid8 = 8'h00;
    cycle8("idle", 8'h00, 0, 0);
    chk("idle_valid", 64'(out_valid8), 64'd0);
    chk("idle_data", 64'(out_data8), 64'hA5);
    chk("idle_sel", 64'(out_sel8), 64'd3);

    // Round-robin from PTR=0 over all channels, wrapping back to 0
    mode8 = 1'b1;
    in_valid8 = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      cycle8($sformatf("rr%0d", k), 8'(1 << (k % 8)), 1, k % 8);
    end

    // Backpressure: held word must not move while inputs and S churn
    mode8 = 1'b0;
    s8 = 3'd2;
    setd8(2, 8'h3C);
    in_valid8 = 8'h04;
    cycle8("bp_load", 8'h04, 1, 2);
    out_ready8 = 1'b0;
    for (int j = 0; j < 3; j++) begin
      s8 = s_seq[j];
      in_valid8 = j[0] ? 8'h55 : 8'hFF;
      setd8(5, 8'h11 + 8'(j));
      cycle8($sformatf("bp_hold%0d", j), 8'h00, 0, 0);
      chk("bp_hold_valid", 64'(out_valid8), 64'd1);
      chk("bp_hold_data", 64'(out_data8), 64'h3C);
      chk("bp_hold_sel", 64'(out_sel8), 64'd2);
    end
    out_ready8 = 1'b1;
    s8 = 3'd5;
    in_valid8 = 8'hFF;
    setd8(5, 8'h77);
    cycle8("bp_release", 8'h20, 1, 5);

    // Round-robin wrap from PTR=6 with channels 0 and 2 requesting
    mode8 = 1'b1;
    in_valid8 = 8'h20;
    cycle8("rr_to6", 8'h20, 1, 5);
    in_valid8 = 8'h05;
    cycle8("rr_p6", 8'h01, 1, 0);
    cycle8("rr_p1", 8'h04, 1, 2);
    cycle8("rr_p3", 8'h01, 1, 0);

    // Mode switch takes effect immediately; PTR holds through fixed mode
    mode8 = 1'b0;
    s8 = 3'd2;
    cycle8("fix_s2", 8'h04, 1, 2);
    mode8 = 1'b1;
    cycle8("rr_held", 8'h04, 1, 2);

    // N=5 instance: out-of-range select yields no grant; held word drains
    in_valid8 = 8'h00;
    in_valid5 = 5'h1F;
    s5 = 3'd1;
    cycle5("n5_s1", 5'h02, 1, 1);
    s5 = 3'd6;
    out_ready5 = 1'b0;
    cycle5("n5_s6_hold", 5'h00, 0, 0);
    chk("n5_hold_valid", 64'(out_valid5), 64'd1);
    out_ready5 = 1'b1;
    cycle5("n5_s6_drain", 5'h00, 0, 0);
    chk("n5_drain_valid", 64'(out_valid5), 64'd0);
    chk("n5_drain_data", 64'(out_data5), 64'h51);
    chk("n5_drain_sel", 64'(out_sel5), 64'd1);

    // N=5 round-robin wraps from 4 to 0
    mode5 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle5($sformatf("n5_rr%0d", k), 5'(1 << (k % 5)), 1, k % 5);
    end
    in_valid5 = 5'h00;

    // Asynchronous reset mid-cycle while a word is held
    mode8 = 1'b0;
    s8 = 3'd4;
    setd8(4, 8'hC4);
    in_valid8 = 8'h10;
    cycle8("pre_rst", 8'h10, 1, 4);
    out_ready8 = 1'b0;
    in_valid8 = 8'h00;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid8), 64'd0);
    chk("arst_data", 64'(out_data8), 64'd0);
    chk("arst_sel", 64'(out_sel8), 64'd0);
    chk("arst_rdy", 64'(in_ready8), 64'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mode8 = 1'b1;
    out_ready8 = 1'b1;
    in_valid8 = 8'hFF;
    cycle8("rst_rr", 8'h01, 1, 0);

    chk("sb8_empty", 64'(sb8.size()), 64'd0);
    chk("sb5_empty", 64'(sb5.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_mux.md
STREAM_MUX -- requirements
Module: stream_mux

Interface
REQ-001 Parameter N, default 8, is the number of input channels (2..32).
REQ-002 Parameter W, default 8, is the data width per channel in bits (1..64).
REQ-003 Parameter SW, default $clog2(N), is the select and index width.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 CLK  input  1  clock; all state updates on rising edge.
REQ-006 RST_N  input  1  asynchronous active-low reset.
REQ-007 IN_DATA  input  N*W  channel i occupies bits [i*W+W-1 : i*W].
REQ-008 IN_VALID  input  N  per-channel valid.
REQ-009 IN_READY  output  N  per-channel ready; combinational.
REQ-010 S  input  SW  fixed-mode channel select.
REQ-011 MODE  input  1  0 = fixed select via S, 1 = round-robin.
REQ-012 OUT_DATA  output  W  registered selected data.
REQ-013 OUT_VALID  output  1  registered valid.
REQ-014 OUT_READY  input  1  downstream ready.
REQ-015 OUT_SEL  output  SW  registered index of the channel that supplied OUT_DATA.

Function
REQ-016 Handshake: a transfer occurs on any edge where valid and ready are both 1; the data SHALL NOT change while valid=1 and ready=0.
REQ-017 load = !OUT_VALID || OUT_READY; the output register SHALL accept a new word only when load=1.
REQ-018 Fixed mode: the grant goes to channel S iff S<N and IN_VALID[S]=1; S>=N SHALL produce no grant.
REQ-019 Round-robin mode: the grant goes to the first channel with IN_VALID=1, searching upward from PTR and wrapping from N-1 to 0.
REQ-020 IN_READY[i] SHALL be load AND grant[i]; at most one IN_READY bit is high in any cycle.
REQ-021 When a channel is granted and load=1: on the next edge OUT_DATA, OUT_SEL and OUT_VALID SHALL load the granted word, its index and 1 (latency 1 cycle).
REQ-022 When load=1 and no channel is granted, OUT_VALID SHALL go to 0; OUT_DATA and OUT_SEL SHALL hold.
REQ-023 Full throughput: back-to-back transfers at one word per cycle SHALL be sustained when OUT_READY=1.
REQ-024 PTR (SW bits, internal) SHALL update only on a round-robin transfer, to (granted index + 1) mod N; this includes the wrap N-1 -> 0.
REQ-025 PTR SHALL hold in fixed mode. A MODE change SHALL take effect on the same cycle's grant, with no flush.
REQ-026 S and MODE SHALL be sampled combinationally every cycle; a change while OUT_VALID=1 and OUT_READY=0 SHALL NOT affect the held output.
REQ-027 Simultaneous OUT_READY=1 and a new grant SHALL unload the old word and load the new one on the same edge, with no bubble.

Reset
REQ-028 While RST_N=0: OUT_VALID=0, OUT_DATA=0, OUT_SEL=0 and PTR=0, regardless of the clock.
REQ-029 While RST_N=0, IN_READY SHALL be 0 because load is gated by reset.
REQ-030 Reset asserted mid-transfer SHALL discard the held word with no partial output.
REQ-031 After RST_N deasserts, the first grant SHALL occur on the first rising edge.

Verification
REQ-032 Fixed mode, N=8, W=8, S=3, IN_VALID=8'h08, channel 3 data=8'hA5, OUT_READY=1 -> next cycle OUT_VALID=1, OUT_DATA=8'hA5, OUT_SEL=3; IN_READY=8'h08 in the request cycle.
REQ-033 Round-robin, IN_VALID=8'hFF held, OUT_READY=1, PTR=0 -> OUT_SEL sequence 0,1,...,7,0 on consecutive cycles with no bubbles.
REQ-034 Backpressure: OUT_VALID=1 with OUT_DATA=8'h3C, OUT_READY=0 for 3 cycles while S changes and inputs toggle -> OUT_DATA stays 8'h3C, OUT_SEL stays put, IN_READY=0; on OUT_READY=1 the new word loads on the next edge.
REQ-035 Round-robin, PTR=6, IN_VALID=8'b0000_0101 -> grant channel 0, then PTR=1, then grant channel 2, then PTR=3.
REQ-036 N=5 instance, fixed mode, S=6 with all IN_VALID=1 -> no grant, IN_READY=0, OUT_VALID falls to 0 after the held word drains.
REQ-037 RST_N pulsed low asynchronously between edges while OUT_VALID=1 -> OUT_VALID=0 immediately; after release, round-robin restarts at PTR=0.
